// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a 4-digit common-anode seven-segment display.
//
// Lights one digit at a time in the order 0,1,2,3. Each digit gets a slot of SCAN_DIV
// cycles. The first DEAD_CYC cycles of every slot are dark, which prevents ghosting
// between digits. The four digit patterns are sampled once per frame, at the start of
// slot 0, so a digit never changes while a frame is being drawn.
//
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (>= 2)
//   DEAD_CYC  dark cycles at the start of each slot (0 <= DEAD_CYC < SCAN_DIV)
//   SEG_OFF   segment bus value driven while no digit is lit
//
// Ports:
//   ck_i      system clock
//   rst_i     synchronous active-high reset
//   dig0_i    segment pattern for digit 0 (rightmost), polarity passed through
//   dig1_i    segment pattern for digit 1
//   dig2_i    segment pattern for digit 2
//   dig3_i    segment pattern for digit 3
//   blank_i   forces the display dark while high; scan timing keeps running
//   bright_i  brightness level 0..3 (only with SEVEN_SEG_SCANNER_DIM_EN)
//   seg_o     shared segment bus, registered
//   an_o      active-low anode enables, registered; bit k enables digit k
//
// Build option: define SEVEN_SEG_SCANNER_DIM_EN to add bright_i. The lit part of each
// slot is then shortened to ((SCAN_DIV-DEAD_CYC)*(br+1))>>2 cycles, where br is the
// brightness level sampled at the frame snapshot.
module seven_seg_scanner #(
    parameter int         SCAN_DIV = 50000,
    parameter int         DEAD_CYC = 500,
    parameter logic [6:0] SEG_OFF  = 7'h7F
) (
    input  logic       ck_i,
    input  logic       rst_i,
    input  logic [6:0] dig0_i,
    input  logic [6:0] dig1_i,
    input  logic [6:0] dig2_i,
    input  logic [6:0] dig3_i,
    input  logic       blank_i,
`ifdef SEVEN_SEG_SCANNER_DIM_EN
    input  logic [1:0] bright_i,
`endif
    output logic [6:0] seg_o,
    output logic [3:0] an_o
);

    localparam int CW  = $clog2(SCAN_DIV);
    localparam int CW1 = CW + 1;
    localparam logic [CW-1:0] C_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] C_DEAD = CW'(DEAD_CYC);

    logic [CW-1:0] c;
    logic [1:0]    idx;
    logic [6:0]    snap [4];
    logic          frame_start;
    logic          lit;

    assign frame_start = (idx == 2'd0) && (c == '0);

`ifdef SEVEN_SEG_SCANNER_DIM_EN
    // End of the lit window (exclusive) for each brightness level. The products are
    // formed in 32-bit integer arithmetic so nothing is truncated before the shift.
    localparam int SPAN = SCAN_DIV - DEAD_CYC;
    localparam logic [CW:0] END0 = CW1'(DEAD_CYC + ((SPAN * 1) >> 2));
    localparam logic [CW:0] END1 = CW1'(DEAD_CYC + ((SPAN * 2) >> 2));
    localparam logic [CW:0] END2 = CW1'(DEAD_CYC + ((SPAN * 3) >> 2));
    localparam logic [CW:0] END3 = CW1'(DEAD_CYC + ((SPAN * 4) >> 2));

    logic [1:0]  br;
    logic [CW:0] lit_end;

    always_comb begin
        lit_end = (br == 2'd0) ? END0 :
                  (br == 2'd1) ? END1 :
                  (br == 2'd2) ? END2 : END3;
        lit     = !blank_i && (c >= C_DEAD) && ({1'b0, c} < lit_end);
    end

    // Brightness is frozen per frame, alongside the digit patterns.
    always_ff @(posedge ck_i) begin
        if (rst_i)
            br <= 2'd3;
        else if (frame_start)
            br <= bright_i;
    end
`else
    always_comb lit = !blank_i && (c >= C_DEAD);
`endif

    // Prescaler and slot index: c runs 0..SCAN_DIV-1, idx advances on each wrap.
    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            c   <= '0;
            idx <= 2'd0;
        end else begin
            c   <= (c == C_LAST) ? '0 : c + 1'b1;
            idx <= (c == C_LAST) ? idx + 2'd1 : idx;
        end
    end

    // Per-frame snapshot of the digit patterns.
    always_ff @(posedge ck_i) begin
        if (rst_i)
            snap <= '{default: SEG_OFF};
        else if (frame_start)
            snap <= '{dig0_i, dig1_i, dig2_i, dig3_i};
    end

    // Registered outputs: a function of the scan state before the edge.
    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            an_o  <= 4'hF;
            seg_o <= SEG_OFF;
        end else begin
            an_o  <= lit ? ~(4'b0001 << idx) : 4'hF;
            seg_o <= lit ? snap[idx] : SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scoreboard bench for seven_seg_scanner with a time-based reference model.
module tb_seven_seg_scanner;

    localparam int SD = 8;
    localparam int DC = 2;
    localparam int FR = 4 * SD;

    logic       ck_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] dig0_i = '0, dig1_i = '0, dig2_i = '0, dig3_i = '0;
    logic       blank_i = 1'b0;
    logic [1:0] bright_i = 2'd3;
    logic [6:0] seg_o;
    logic [3:0] an_o;

    seven_seg_scanner #(.SCAN_DIV(SD), .DEAD_CYC(DC), .SEG_OFF(7'h7F)) dut (
        .ck_i    (ck_i),
        .rst_i   (rst_i),
        .dig0_i  (dig0_i),
        .dig1_i  (dig1_i),
        .dig2_i  (dig2_i),
        .dig3_i  (dig3_i),
        .blank_i (blank_i),
`ifdef SEVEN_SEG_SCANNER_DIM_EN
        .bright_i(bright_i),
`endif
        .seg_o   (seg_o),
        .an_o    (an_o)
    );

    always #5 ck_i = ~ck_i;

    logic [10:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: m_t counts edges since the last reset edge. The scan position is
    // pure arithmetic on that count; frame snapshots happen every FR edges.
    int         m_t = 0;
    logic [6:0] m_snap [4] = '{default: 7'h7F};
    int         m_br = 3;

    always @(negedge ck_i) begin
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({an_o, seg_o} !== e) begin
                errors++;
                $display("FAIL scan cyc=%0d an=%b seg=%h expected an=%b seg=%h",
                         cyc, an_o, seg_o, e[10:7], e[6:0]);
            end
            cyc++;
        end
    end

    task automatic step();
        logic [3:0] ea;
        logic [6:0] es;
        logic [3:0] one;
        int cpos, slot, len;
        bit lit;
        one = 4'b0001;
        ea = 4'hF;
        es = 7'h7F;
        if (rst_i) begin
            m_t    = 0;
            m_snap = '{default: 7'h7F};
            m_br   = 3;
        end else begin
            cpos = m_t % SD;
            slot = (m_t / SD) % 4;
`ifdef SEVEN_SEG_SCANNER_DIM_EN
            len = ((SD - DC) * (m_br + 1)) >> 2;
`else
            len = SD - DC;
`endif
            lit = !blank_i && cpos >= DC && cpos < DC + len;
            if (lit) begin
                ea = ~(one << slot);
                es = m_snap[slot];
            end
            if (m_t % FR == 0) begin
                m_snap = '{dig0_i, dig1_i, dig2_i, dig3_i};
                m_br   = int'(bright_i);
            end
            m_t++;
        end
        exp_q.push_back({ea, es});
        @(posedge ck_i);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic seek(input int pos);
        for (int i = 0; i < FR + 1 && (m_t % FR) != pos; i++) step();
    endtask

    initial begin
        dig0_i = 7'(($urandom_range(0, 127)));
        dig1_i = 7'(($urandom_range(0, 127)));
        dig2_i = 7'(($urandom_range(0, 127)));
        dig3_i = 7'(($urandom_range(0, 127)));
        rst_i = 1'b1;
        run(5);
        dig0_i = 7'h40; dig1_i = 7'h79; dig2_i = 7'h24; dig3_i = 7'h30;
        rst_i = 1'b0;
        run(2 * FR);
        // Snapshot isolation: change digit 2 while slot 1 is lit.
        seek(SD + 3);
        dig2_i = 7'h12;
        run(2 * FR);
        // Blank for 10 cycles starting mid-slot 1.
        seek(SD + 3);
        blank_i = 1'b1;
        run(10);
        blank_i = 1'b0;
        run(FR + 8);
        // One-cycle reset while slot 2 is lit.
        seek(2 * SD + 4);
        rst_i = 1'b1;
        run(1);
        rst_i = 1'b0;
        run(2 * FR);
`ifdef SEVEN_SEG_SCANNER_DIM_EN
        bright_i = 2'd1;
        run(2 * FR);
        bright_i = 2'd0;
        run(2 * FR);
        seek(SD + 3);
        bright_i = 2'd2;
        run(2 * FR);
`endif
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) dig0_i = 7'(($urandom_range(0, 127)));
            if ($urandom_range(0, 15) == 0) dig1_i = 7'(($urandom_range(0, 127)));
            if ($urandom_range(0, 15) == 0) dig2_i = 7'(($urandom_range(0, 127)));
            if ($urandom_range(0, 15) == 0) dig3_i = 7'(($urandom_range(0, 127)));
            if ($urandom_range(0, 31) == 0) blank_i = ~blank_i;
            if ($urandom_range(0, 63) == 0) bright_i = 2'($urandom_range(0, 3));
            rst_i = ($urandom_range(0, 299) == 0);
            step();
        end
        rst_i = 1'b0;
        blank_i = 1'b0;
        run(FR);
        @(negedge ck_i);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
